// File: rtl/ahb3lite_sram1rw_ws_pkg.sv
// AHB3-Lite protocol constants and the byte-lane enable helper shared by the
// SRAM slave and its bench.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_B8    = 3'b000;
    localparam logic [2:0] HSIZE_B16   = 3'b001;
    localparam logic [2:0] HSIZE_B32   = 3'b010;
    localparam logic [2:0] HSIZE_B64   = 3'b011;
    localparam logic [2:0] HSIZE_B128  = 3'b100;
    localparam logic [2:0] HSIZE_B256  = 3'b101;
    localparam logic [2:0] HSIZE_B512  = 3'b110;
    localparam logic [2:0] HSIZE_B1024 = 3'b111;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Byte enables for a bus of nbytes lanes (1..8); sizes wider than the bus
    // saturate to a full-width access, the offset is aligned down to the size.
    function automatic logic [7:0] gen_be(input logic [2:0] hsize,
                                          input logic [2:0] addr,
                                          input int unsigned nbytes);
        int unsigned sz;
        int unsigned off;
        logic [15:0] mask;
        sz = 32'd1 << hsize;
        if (sz > nbytes) sz = nbytes;
        off  = {29'd0, addr} & (nbytes - 32'd1) & ~(sz - 32'd1);
        mask = (16'd1 << sz) - 16'd1;
        mask = mask << off;
        return mask[7:0];
    endfunction

endpackage

// File: rtl/ahb3lite_sram1rw_ws_if.sv
// AHB3-Lite slave-port bundle; clock and reset are kept outside as plain ports.
interface ahb3lite_sram1rw_ws_if #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HREADYOUT;
    logic                  HREADY;
    logic                  HRESP;

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb3lite_sram1rw_ws_rl_ram_1r1w.sv
// Two-port RAM wrapper: byte-enabled write port, registered read with one
// cycle latency; a read colliding with a write returns the old word.
module rl_ram_1r1w #(
    parameter int unsigned ABITS      = 8,
    parameter int unsigned DBITS      = 32,
    parameter string       TECHNOLOGY = "GENERIC",
    parameter string       INIT_FILE  = ""
) (
    input  logic               i_rst_n,
    input  logic               i_clk,
    input  logic [ABITS-1:0]   i_waddr,
    input  logic [DBITS-1:0]   i_din,
    input  logic               i_we,
    input  logic [DBITS/8-1:0] i_be,
    input  logic [ABITS-1:0]   i_raddr,
    input  logic               i_re,
    output logic [DBITS-1:0]   o_dout
);
    // Only the generic behavioural array exists in this codebase.
    localparam bit cfg_unused = (TECHNOLOGY == "") && (INIT_FILE == "");

    logic [DBITS-1:0] r_mem [2**ABITS];
    logic [DBITS-1:0] r_dout;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < DBITS/8; b++) begin
                if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_din[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_dout <= '0;
        else if (i_re) r_dout <= r_mem[i_raddr];
    end

    assign o_dout = r_dout;
endmodule

// File: rtl/ahb3lite_sram1rw_ws.sv
// AHB3-Lite SRAM slave with per-direction wait states, byte-lane writes and
// write->read forwarding. Optional range check: AHB3LITE_SRAM_RANGE_CHECK_EN.
module ahb3lite_sram1rw_ws
    import ahb3lite_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned RD_WAIT    = 0,
    parameter int unsigned WR_WAIT    = 0,
    parameter string       TECHNOLOGY = "GENERIC",
    parameter string       INIT_FILE  = ""
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    ahb3lite_sram1rw_ws_if.slave bus
);
    localparam int unsigned BE_W = HDATA_SIZE / 8;
    localparam int unsigned AB   = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int unsigned IW   = $clog2(MEM_DEPTH);
    localparam logic [3:0]  RD_W = 4'(RD_WAIT);
    localparam logic [3:0]  WR_W = 4'(WR_WAIT);

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              w_ready, w_resp;

    logic              w_accept, w_addr_err;
    logic [3:0]        w_wait;
    logic [IW-1:0]     w_idx;
    logic [7:0]        w_be_full;
    logic [BE_W-1:0]   w_be;

    logic              r_dp_valid, r_dp_write, r_dp_err;
    logic [IW-1:0]     r_dp_idx;
    logic [BE_W-1:0]   r_dp_be;

    logic              w_we, w_re;
    logic [HDATA_SIZE-1:0] w_ram_dout, w_rdata;
    logic [BE_W-1:0]       r_fwd_be;
    logic [HDATA_SIZE-1:0] r_fwd_data;
    logic                  r_rd_zero;
    logic                  w_unused;

    assign w_accept  = bus.HSEL & bus.HREADY &
                       (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
    assign w_wait    = bus.HWRITE ? WR_W : RD_W;
    assign w_idx     = bus.HADDR[AB +: IW];
    assign w_be_full = gen_be(bus.HSIZE, bus.HADDR[2:0], BE_W);
    assign w_be      = w_be_full[BE_W-1:0];

`ifdef AHB3LITE_SRAM_RANGE_CHECK_EN
    localparam logic [HADDR_SIZE-1:0] ADDR_LIMIT = HADDR_SIZE'(MEM_DEPTH * BE_W);
    assign w_addr_err = (bus.HADDR >= ADDR_LIMIT);
`else
    assign w_addr_err = 1'b0;
`endif

    assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HADDR, w_be_full};

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Any ready cycle (IDLE, WAIT with cnt==0, ERR2) ends the current data
    // phase and may take the next address phase without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = 1'b1;
        w_resp      = HRESP_OKAY;
        unique case (r_state)
            WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_ready   = 1'b0;
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ERR1: begin
                w_ready     = 1'b0;
                w_resp      = HRESP_ERROR;
                w_state_nxt = ERR2;
            end
            ERR2:    w_resp = HRESP_ERROR;
            default: ;
        endcase
        if (w_ready) begin
            if (w_accept && w_addr_err) begin
                w_state_nxt = ERR1;
                w_cnt_nxt   = '0;
            end else if (w_accept && w_wait != 4'd0) begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = w_wait;
            end else begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_err   <= 1'b0;
            r_dp_idx   <= '0;
            r_dp_be    <= '0;
        end else if (w_ready) begin
            r_dp_valid <= w_accept;
            r_dp_write <= bus.HWRITE;
            r_dp_err   <= w_addr_err;
            r_dp_idx   <= w_idx;
            r_dp_be    <= w_be;
        end
    end

    // Reads are launched in the address phase so that RD_WAIT=0 still meets
    // the one-cycle data phase; the RAM output then holds through the waits.
    assign w_we = HRESETn & r_dp_valid & r_dp_write & ~r_dp_err & w_ready;
    assign w_re = HRESETn & w_ready & w_accept & ~bus.HWRITE & ~w_addr_err;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_fwd_be   <= '0;
            r_fwd_data <= '0;
            r_rd_zero  <= 1'b0;
        end else if (w_ready && w_accept && !bus.HWRITE) begin
            r_fwd_be   <= (w_we && r_dp_idx == w_idx) ? r_dp_be : '0;
            r_fwd_data <= bus.HWDATA;
            r_rd_zero  <= w_addr_err;
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int unsigned b = 0; b < BE_W; b++) begin
            w_rdata[b*8 +: 8] = r_fwd_be[b] ? r_fwd_data[b*8 +: 8] : w_ram_dout[b*8 +: 8];
        end
        if (r_rd_zero) w_rdata = '0;
    end

    rl_ram_1r1w #(
        .ABITS      (IW),
        .DBITS      (HDATA_SIZE),
        .TECHNOLOGY (TECHNOLOGY),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .i_rst_n (HRESETn),
        .i_clk   (HCLK),
        .i_waddr (r_dp_idx),
        .i_din   (bus.HWDATA),
        .i_we    (w_we),
        .i_be    (r_dp_be),
        .i_raddr (w_idx),
        .i_re    (w_re),
        .o_dout  (w_ram_dout)
    );

    assign bus.HRDATA    = w_rdata;
    assign bus.HREADYOUT = w_ready;
    assign bus.HRESP     = w_resp;
endmodule

// File: tb/tb_ahb3lite_sram1rw_ws.sv
// Directed bench: three slave instances (wait configs 0/0, 2/3, 1/4) driven
// from one pipelined AHB master sequencer, checked against hand values.
module tb_ahb3lite_sram1rw_ws;

    logic        clk = 1'b0;
    logic [2:0]  rstn;
    logic [2:0]  m_hsel;
    logic [31:0] m_haddr, m_hwdata;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [1:0]  m_htrans;

    logic [2:0]  rdy_v, resp_v;
    logic [31:0] rdata_v [3];
    int          cur;
    logic        w_ready, w_resp;
    logic [31:0] w_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic        s_wr    [8];
    logic [31:0] s_addr  [8];
    logic [2:0]  s_size  [8];
    logic [31:0] s_wdata [8];
    logic [31:0] q_rdata [8];
    logic        q_resp  [8];
    logic        q_resp0 [8];
    int          q_low   [8];
    int          q_cycles;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb3lite_sram1rw_ws_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus ();
        assign bus.HSEL   = m_hsel[g];
        assign bus.HADDR  = m_haddr;
        assign bus.HWDATA = m_hwdata;
        assign bus.HWRITE = m_hwrite;
        assign bus.HSIZE  = m_hsize;
        assign bus.HBURST = 3'b000;
        assign bus.HPROT  = 4'b0011;
        assign bus.HTRANS = m_htrans;
        assign bus.HREADY = bus.HREADYOUT;
        assign rdy_v[g]   = bus.HREADYOUT;
        assign resp_v[g]  = bus.HRESP;
        assign rdata_v[g] = bus.HRDATA;

        ahb3lite_sram1rw_ws #(
            .MEM_DEPTH  (256),
            .HADDR_SIZE (32),
            .HDATA_SIZE (32),
            .RD_WAIT    (g == 1 ? 2 : (g == 2 ? 1 : 0)),
            .WR_WAIT    (g == 1 ? 3 : (g == 2 ? 4 : 0)),
            .TECHNOLOGY ("GENERIC"),
            .INIT_FILE  ("")
        ) u_dut (
            .HCLK    (clk),
            .HRESETn (rstn[g]),
            .bus     (bus)
        );
    end

    assign w_ready = rdy_v[cur];
    assign w_resp  = resp_v[cur];
    assign w_rdata = rdata_v[cur];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_xfer(input int k, input logic wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata);
        s_wr[k]    = wr;
        s_addr[k]  = addr;
        s_size[k]  = size;
        s_wdata[k] = wdata;
    endtask

    // Pipelined master: address phase of k overlaps data phase of k-1.
    task automatic run_seq(input int d, input int n);
        int ap, dp, guard;
        logic rdy;
        bit first;
        ap = 0; dp = -1; guard = 0; first = 0; q_cycles = 0;
        for (int k = 0; k < n; k++) q_low[k] = 0;
        cur = d;
        while ((ap < n || dp >= 0) && guard < 200) begin
            m_hsel    = '0;
            m_hsel[d] = 1'b1;
            if (ap < n) begin
                m_htrans = 2'b10;
                m_haddr  = s_addr[ap];
                m_hwrite = s_wr[ap];
                m_hsize  = s_size[ap];
            end else begin
                m_htrans = 2'b00;
            end
            m_hwdata = (dp >= 0) ? s_wdata[dp] : 32'h0;
            #1;
            rdy = w_ready;
            if (dp >= 0) begin
                if (first) begin
                    q_resp0[dp] = w_resp;
                    first = 0;
                end
                if (rdy) begin
                    q_rdata[dp] = w_rdata;
                    q_resp[dp]  = w_resp;
                end else begin
                    q_low[dp]++;
                end
            end
            @(posedge clk);
            #1;
            q_cycles++;
            guard++;
            if (rdy) begin
                if (ap < n) begin
                    dp = ap;
                    ap++;
                    first = 1;
                end else begin
                    dp = -1;
                end
            end
        end
        m_htrans = 2'b00;
        m_hsel   = '0;
        check_eq("seq_timeout", 64'(guard >= 200), 64'd0);
    endtask

    initial begin
        rstn = '0; m_hsel = '0; m_haddr = '0; m_hwdata = '0;
        m_hwrite = 1'b0; m_hsize = 3'd2; m_htrans = 2'b00; cur = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            cur = d;
            #1;
            check_eq("rst_hreadyout", 64'(w_ready), 64'd1);
            check_eq("rst_hresp", 64'(w_resp), 64'd0);
            check_eq("rst_hrdata", 64'(w_rdata), 64'd0);
        end
        rstn = '1;
        @(posedge clk);
        #1;

        // zero-wait write then back-to-back read (forwarded), then plain read
        set_xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        set_xfer(1, 1'b0, 32'h10, 3'd2, 32'h0);
        run_seq(0, 2);
        check_eq("zw_fwd_rdata", 64'(q_rdata[1]), 64'hDEADBEEF);
        check_eq("zw_low_total", 64'(q_low[0] + q_low[1]), 64'd0);
        check_eq("zw_cycles", 64'(q_cycles), 64'd3);
        set_xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
        run_seq(0, 1);
        check_eq("zw_ram_rdata", 64'(q_rdata[0]), 64'hDEADBEEF);
        check_eq("zw_ram_low", 64'(q_low[0]), 64'd0);

        // byte / halfword merges through forwarding and through the RAM
        set_xfer(0, 1'b1, 32'h20, 3'd2, 32'h11223344);
        set_xfer(1, 1'b1, 32'h21, 3'd0, 32'h0000AA00);
        set_xfer(2, 1'b0, 32'h20, 3'd2, 32'h0);
        run_seq(0, 3);
        check_eq("byte_fwd", 64'(q_rdata[2]), 64'h1122AA44);
        set_xfer(0, 1'b0, 32'h20, 3'd2, 32'h0);
        run_seq(0, 1);
        check_eq("byte_ram", 64'(q_rdata[0]), 64'h1122AA44);
        set_xfer(0, 1'b1, 32'h30, 3'd2, 32'hAABBCCDD);
        set_xfer(1, 1'b1, 32'h32, 3'd1, 32'h55660000);
        set_xfer(2, 1'b0, 32'h30, 3'd2, 32'h0);
        run_seq(0, 3);
        check_eq("half_fwd", 64'(q_rdata[2]), 64'h5566CCDD);

        // a write to another word must not leak into a concurrent read
        set_xfer(0, 1'b1, 32'h54, 3'd2, 32'h9ABCDEF0);
        run_seq(0, 1);
        set_xfer(0, 1'b1, 32'h50, 3'd2, 32'h11111111);
        set_xfer(1, 1'b0, 32'h54, 3'd2, 32'h0);
        run_seq(0, 2);
        check_eq("no_fwd_other_word", 64'(q_rdata[1]), 64'h9ABCDEF0);

        // out-of-range address
        set_xfer(0, 1'b1, 32'h0, 3'd2, 32'h600DF00D);
        run_seq(0, 1);
`ifdef AHB3LITE_SRAM_RANGE_CHECK_EN
        set_xfer(0, 1'b0, 32'h400, 3'd2, 32'h0);
        run_seq(0, 1);
        check_eq("err_low", 64'(q_low[0]), 64'd1);
        check_eq("err_resp_first", 64'(q_resp0[0]), 64'd1);
        check_eq("err_resp_last", 64'(q_resp[0]), 64'd1);
        check_eq("err_rdata", 64'(q_rdata[0]), 64'd0);
        set_xfer(0, 1'b1, 32'h400, 3'd2, 32'h0BADC0DE);
        set_xfer(1, 1'b0, 32'h0, 3'd2, 32'h0);
        run_seq(0, 2);
        check_eq("err_wr_resp", 64'(q_resp[0]), 64'd1);
        check_eq("err_mem0_kept", 64'(q_rdata[1]), 64'h600DF00D);
        check_eq("err_rd_resp_okay", 64'(q_resp[1]), 64'd0);
`else
        set_xfer(0, 1'b1, 32'h400, 3'd2, 32'h0BADC0DE);
        run_seq(0, 1);
        check_eq("wrap_wr_resp", 64'(q_resp[0]), 64'd0);
        check_eq("wrap_wr_low", 64'(q_low[0]), 64'd0);
        set_xfer(0, 1'b0, 32'h0, 3'd2, 32'h0);
        run_seq(0, 1);
        check_eq("wrap_mem0", 64'(q_rdata[0]), 64'h0BADC0DE);
        check_eq("wrap_rd_resp", 64'(q_resp[0]), 64'd0);
`endif

        // RD_WAIT=2 / WR_WAIT=3
        set_xfer(0, 1'b1, 32'h04, 3'd2, 32'hCAFEF00D);
        run_seq(1, 1);
        check_eq("ws_wr_low", 64'(q_low[0]), 64'd3);
        set_xfer(0, 1'b0, 32'h04, 3'd2, 32'h0);
        run_seq(1, 1);
        check_eq("ws_rd_low", 64'(q_low[0]), 64'd2);
        check_eq("ws_rd_rdata", 64'(q_rdata[0]), 64'hCAFEF00D);
        set_xfer(0, 1'b1, 32'h08, 3'd2, 32'h01020304);
        set_xfer(1, 1'b0, 32'h08, 3'd2, 32'h0);
        run_seq(1, 2);
        check_eq("ws_b2b_rdata", 64'(q_rdata[1]), 64'h01020304);
        check_eq("ws_b2b_cycles", 64'(q_cycles), 64'd8);

        // RD_WAIT=1 / WR_WAIT=4 back-to-back NONSEQ
        set_xfer(0, 1'b1, 32'h0, 3'd2, 32'hA5A50001);
        set_xfer(1, 1'b0, 32'h0, 3'd2, 32'h0);
        set_xfer(2, 1'b1, 32'h4, 3'd2, 32'h5A5A0002);
        run_seq(2, 3);
        check_eq("b2b_cycles", 64'(q_cycles), 64'd13);
        check_eq("b2b_rd_low", 64'(q_low[1]), 64'd1);
        check_eq("b2b_rdata", 64'(q_rdata[1]), 64'hA5A50001);
        set_xfer(0, 1'b0, 32'h4, 3'd2, 32'h0);
        run_seq(2, 1);
        check_eq("b2b_wr2_rdata", 64'(q_rdata[0]), 64'h5A5A0002);

        // reset during a WR_WAIT=4 data phase drops the write
        set_xfer(0, 1'b1, 32'h40, 3'd2, 32'h12345678);
        run_seq(2, 1);
        cur = 2;
        m_hsel = 3'b100; m_htrans = 2'b10; m_haddr = 32'h40;
        m_hwrite = 1'b1; m_hsize = 3'd2;
        @(posedge clk);
        #1;
        m_htrans = 2'b00;
        m_hwdata = 32'hFFFFFFFF;
        #1;
        check_eq("rstmid_wait_low", 64'(w_ready), 64'd0);
        @(posedge clk);
        #1;
        rstn[2] = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rstmid_hreadyout", 64'(w_ready), 64'd1);
        check_eq("rstmid_hresp", 64'(w_resp), 64'd0);
        rstn[2] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        set_xfer(0, 1'b0, 32'h40, 3'd2, 32'h0);
        run_seq(2, 1);
        check_eq("rstmid_word_kept", 64'(q_rdata[0]), 64'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
